// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle between the three requesters, the arbiter and the register file.
interface regfile_wr_arbiter_if;
    logic [2:0]  req_i;
    logic [2:0]  lock_i;
    logic [3:0]  addr0_i;
    logic [3:0]  addr1_i;
    logic [3:0]  addr2_i;
    logic [15:0] data0_i;
    logic [15:0] data1_i;
    logic [15:0] data2_i;
    logic [2:0]  ack_o;
    logic        write_en;
    logic [3:0]  wrData;
    logic [15:0] DataIn;
    logic        locked_o;
    logic [1:0]  owner_o;

    modport slave (
        input  req_i, lock_i, addr0_i, addr1_i, addr2_i, data0_i, data1_i, data2_i,
        output ack_o, write_en, wrData, DataIn, locked_o, owner_o
    );

    modport master (
        output req_i, lock_i, addr0_i, addr1_i, addr2_i, data0_i, data1_i, data2_i,
        input  ack_o, write_en, wrData, DataIn, locked_o, owner_o
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file write port, with locked bursts (optional CORE_PRIORITY_EN).
// Latency: ack is combinational; the accepted beat reaches the register file one cycle later.
// Backpressure: losers and non-owners during a lock see ack 0 and hold their request.
module regfile_wr_arbiter #(
    parameter int MAX_LOCK = 8
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wr_arbiter_if.slave bus
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;
    localparam logic [1:0] NO_OWNER = 2'd3;

    logic [0:0]  state, state_nxt;
    logic [1:0]  rr_ptr, rr_nxt;
    logic [1:0]  owner, owner_nxt;
    logic [3:0]  beat_cnt, cnt_nxt, cnt_inc;
    logic [1:0]  win;
    logic        grant;
    logic [2:0]  ack;
    logic [3:0]  win_addr;
    logic [15:0] win_data;
    logic        wen_q;
    logic [3:0]  wr_addr_q;
    logic [15:0] wr_data_q;

    function automatic logic [1:0] wrap_add(input logic [1:0] base, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, k};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        cnt_nxt   = beat_cnt;
        cnt_inc   = beat_cnt + 4'd1;
        grant     = 1'b0;
        win       = 2'd0;
        ack       = 3'b000;
        if (state == IDLE) begin
            // Scan downward so the candidate closest to rr_ptr overwrites the others.
            for (int k = 2; k >= 0; k--) begin
                if (bus.req_i[wrap_add(rr_ptr, 2'(k))]) begin
                    grant = 1'b1;
                    win   = wrap_add(rr_ptr, 2'(k));
                end
            end
`ifdef CORE_PRIORITY_EN
            if (bus.req_i[0]) begin
                grant = 1'b1;
                win   = 2'd0;
            end
`endif
            if (grant) begin
                rr_nxt = wrap_add(win, 2'd1);
                if (bus.lock_i[win] && MAX_LOCK > 1) begin
                    state_nxt = LOCKED;
                    owner_nxt = win;
                    cnt_nxt   = 4'd1;
                end
            end
        end else begin
            if (bus.req_i[owner]) begin
                grant = 1'b1;
                win   = owner;
            end
`ifdef CORE_PRIORITY_EN
            if (bus.req_i[0] && owner != 2'd0) begin
                grant = 1'b1;
                win   = 2'd0;
            end
`endif
            // beat_cnt counts beats already taken, so this beat is number cnt_inc.
            if (!grant || win != owner || !bus.lock_i[owner] || cnt_inc == 4'(MAX_LOCK)) begin
                state_nxt = IDLE;
                owner_nxt = NO_OWNER;
                cnt_nxt   = 4'd0;
                rr_nxt    = (grant && win != owner) ? wrap_add(win, 2'd1) : wrap_add(owner, 2'd1);
            end else begin
                cnt_nxt = cnt_inc;
            end
        end
        if (grant) ack[win] = 1'b1;
    end

    always_comb begin
        case (win)
            2'd0:    begin win_addr = bus.addr0_i; win_data = bus.data0_i; end
            2'd1:    begin win_addr = bus.addr1_i; win_data = bus.data1_i; end
            default: begin win_addr = bus.addr2_i; win_data = bus.data2_i; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 2'd0;
            owner     <= NO_OWNER;
            beat_cnt  <= 4'd0;
            wen_q     <= 1'b0;
            wr_addr_q <= 4'd0;
            wr_data_q <= 16'd0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            owner    <= owner_nxt;
            beat_cnt <= cnt_nxt;
            // Register 0 is hard zero: its beats are consumed without a strobe.
            wen_q    <= grant && (win_addr != 4'd0);
            if (grant && win_addr != 4'd0) begin
                wr_addr_q <= win_addr;
                wr_data_q <= win_data;
            end
        end
    end

    assign bus.ack_o    = ack;
    assign bus.write_en = wen_q;
    assign bus.wrData   = wr_addr_q;
    assign bus.DataIn   = wr_data_q;
    assign bus.locked_o = (state == LOCKED);
    assign bus.owner_o  = owner;
endmodule
